// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator cargo controller sensor stage.
//   estado_t      : floor-tracking FSM states
//   N_ANDARES_DEF : default number of floors/sensors
//   ANDAR_W       : width of the floor code driven to the datapath
package elevador_pkg;

  typedef enum logic [1:0] {
    INICIAL,
    NO_ANDAR,
    ENTRE_ANDARES,
    FALHA
  } estado_t;

  localparam int unsigned N_ANDARES_DEF = 4;
  localparam int unsigned ANDAR_W       = 4;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debounce filter.
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-low
//   entrada : synchronised input bit
//   saida   : filtered bit; follows entrada only after it has differed
//             for DEBOUNCE_CICLOS consecutive cycles
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CICLOS = 50000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CICLOS + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic saida
);

  logic [CNT_W-1:0] contador;

  // The update happens on the edge where the counter would reach
  // DEBOUNCE_CICLOS, so the filtered value changes after exactly
  // DEBOUNCE_CICLOS cycles of disagreement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contador <= '0;
      saida    <= 1'b0;
    end else if (entrada == saida) begin
      contador <= '0;
    end else if (contador == CNT_W'(DEBOUNCE_CICLOS - 1)) begin
      contador <= '0;
      saida    <= entrada;
    end else begin
      contador <= contador + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_andar.sv
// Floor sensor conditioning: synchronise, debounce, decode and track the
// current floor with a plausibility check against motor direction.
//   clock            : system clock, rising edge
//   reset            : asynchronous, active-low
//   sensoresNeg      : raw floor sensors, active-low
//   motorSubindo     : motor commanded up
//   motorDescendo    : motor commanded down
//   andarAtual       : last valid floor index, zero-extended
//   andarValido      : car sits on a recognised floor
//   bordaSensorAtivo : one-cycle arrival pulse
//   falhaSensor      : sticky fault, cleared only by reset
//   db_filtrado      : debounced sensors, active-high
module sensor_andar
  import elevador_pkg::*;
#(
  parameter int unsigned N_ANDARES       = N_ANDARES_DEF,
  parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_ANDARES-1:0] sensoresNeg,
  input  logic                 motorSubindo,
  input  logic                 motorDescendo,
  output logic [ANDAR_W-1:0]   andarAtual,
  output logic                 andarValido,
  output logic                 bordaSensorAtivo,
  output logic                 falhaSensor,
  output logic [N_ANDARES-1:0] db_filtrado
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CICLOS + 1);

  // Synchroniser holds raw (active-low) levels so reset means "no sensor".
  logic [N_ANDARES-1:0] sinc1, sinc2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1 <= '1;
      sinc2 <= '1;
    end else begin
      sinc1 <= sensoresNeg;
      sinc2 <= sinc1;
    end
  end

  for (genvar g = 0; g < N_ANDARES; g++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
      .CNT_W           (CNT_W)
    ) u_db (
      .clock   (clock),
      .reset   (reset),
      .entrada (~sinc2[g]),
      .saida   (db_filtrado[g])
    );
  end

  // Decode of the filtered vector.
  int unsigned        qtd;
  logic [ANDAR_W-1:0] indice;
  logic               zero, um_quente, multi;

  always_comb begin
    qtd    = 0;
    indice = '0;
    for (int unsigned i = 0; i < N_ANDARES; i++) begin
      if (db_filtrado[i]) begin
        qtd    = qtd + 1;
        indice = ANDAR_W'(i);
      end
    end
    zero      = (qtd == 0);
    um_quente = (qtd == 1);
    multi     = (qtd > 1);
  end

  estado_t            estado, estado_prox;
  logic [ANDAR_W-1:0] andar_prox;
  logic               borda_prox;
  logic [ANDAR_W:0]   andar_ext, indice_ext;

  assign andar_ext  = {1'b0, andarAtual};
  assign indice_ext = {1'b0, indice};

  always_comb begin
    estado_prox = estado;
    andar_prox  = andarAtual;
    borda_prox  = 1'b0;
    unique case (estado)
      INICIAL: begin
        if (um_quente) begin
          estado_prox = NO_ANDAR;
          andar_prox  = indice;
          borda_prox  = 1'b1;
        end else if (multi) begin
          estado_prox = FALHA;
        end
      end
      NO_ANDAR: begin
        if (zero)
          estado_prox = ENTRE_ANDARES;
        else if (multi || indice != andarAtual)
          estado_prox = FALHA;
      end
      ENTRE_ANDARES: begin
        if (multi) begin
          estado_prox = FALHA;
        end else if (um_quente) begin
          if (indice == andarAtual) begin
            estado_prox = NO_ANDAR;
            borda_prox  = 1'b1;
          end else if ((indice_ext == andar_ext + 1'b1 && motorSubindo && !motorDescendo) ||
                       (indice_ext + 1'b1 == andar_ext && motorDescendo && !motorSubindo)) begin
            estado_prox = NO_ANDAR;
            andar_prox  = indice;
            borda_prox  = 1'b1;
          end else begin
            estado_prox = FALHA;
          end
        end
      end
      FALHA: estado_prox = FALHA;
      default: estado_prox = FALHA;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state register and carry no combinational input path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado           <= INICIAL;
      andarAtual       <= '0;
      andarValido      <= 1'b0;
      bordaSensorAtivo <= 1'b0;
      falhaSensor      <= 1'b0;
    end else begin
      estado           <= estado_prox;
      andarAtual       <= andar_prox;
      andarValido      <= (estado_prox == NO_ANDAR);
      bordaSensorAtivo <= borda_prox;
      falhaSensor      <= (estado_prox == FALHA);
    end
  end

endmodule

// File: tb/tb_sensor_andar.sv
module tb_sensor_andar;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sensoresNeg;
  logic       motorSubindo, motorDescendo;
  logic [3:0] andarAtual;
  logic       andarValido, bordaSensorAtivo, falhaSensor;
  logic [3:0] db_filtrado;

  int unsigned n_testes = 0;
  int unsigned n_falhas = 0;

  sensor_andar #(
    .N_ANDARES       (4),
    .DEBOUNCE_CICLOS (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .sensoresNeg      (sensoresNeg),
    .motorSubindo     (motorSubindo),
    .motorDescendo    (motorDescendo),
    .andarAtual       (andarAtual),
    .andarValido      (andarValido),
    .bordaSensorAtivo (bordaSensorAtivo),
    .falhaSensor      (falhaSensor),
    .db_filtrado      (db_filtrado)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // Runs n cycles sampling on the falling edge. Reports the cycle of the
  // first pulse, the number of pulses, the first cycle with andarValido=0,
  // the first cycle with falhaSensor=1 (0 = never), and whether the pulse
  // was ever high on two consecutive samples.
  task automatic observa(input int n, output int prim_borda, output int n_borda,
                         output int prim_inval, output int prim_falha,
                         output int dupla);
    logic ant;
    prim_borda = 0; n_borda = 0; prim_inval = 0; prim_falha = 0; dupla = 0;
    ant = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (bordaSensorAtivo) begin
        n_borda++;
        if (prim_borda == 0) prim_borda = c;
        if (ant) dupla = 1;
      end
      ant = bordaSensorAtivo;
      if (!andarValido && prim_inval == 0) prim_inval = c;
      if (falhaSensor && prim_falha == 0) prim_falha = c;
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reset with a given raw pattern applied, release on a falling edge.
  task automatic reinicia(input logic [3:0] padrao);
    @(negedge clock);
    reset = 1'b0;
    sensoresNeg = padrao;
    motorSubindo = 1'b0;
    motorDescendo = 1'b0;
    ciclos(2);
    reset = 1'b1;
  endtask

  int pb, nb, pi, pf, du;

  initial begin
    reset = 1'b0;
    sensoresNeg = 4'b1110;
    motorSubindo = 1'b0;
    motorDescendo = 1'b0;
    ciclos(3);
    verifica("rst_andar", andarAtual, 0);
    verifica("rst_valido", andarValido, 0);
    verifica("rst_borda", bordaSensorAtivo, 0);
    verifica("rst_falha", falhaSensor, 0);
    verifica("rst_filtro", db_filtrado, 0);

    // 1: release onto floor 0
    reset = 1'b1;
    observa(12, pb, nb, pi, pf, du);
    verifica("t1_borda_ciclo", pb, 7);
    verifica("t1_n_borda", nb, 1);
    verifica("t1_andar", andarAtual, 0);
    verifica("t1_valido", andarValido, 1);

    // 2: climb to floor 1
    motorSubindo = 1'b1;
    sensoresNeg = 4'b1111;
    observa(10, pb, nb, pi, pf, du);
    verifica("t2_inval_ciclo", pi, 7);
    verifica("t2_sem_borda", nb, 0);
    sensoresNeg = 4'b1101;
    observa(12, pb, nb, pi, pf, du);
    verifica("t2_borda_ciclo", pb, 7);
    verifica("t2_n_borda", nb, 1);
    verifica("t2_andar", andarAtual, 1);
    verifica("t2_valido", andarValido, 1);

    // 3: 3-cycle glitch filtered out
    sensoresNeg = 4'b1111;
    ciclos(3);
    sensoresNeg = 4'b1101;
    observa(12, pb, nb, pi, pf, du);
    verifica("t3_sem_borda", nb, 0);
    verifica("t3_sempre_valido", pi, 0);
    verifica("t3_filtro", db_filtrado, 4'b0010);
    verifica("t3_andar", andarAtual, 1);

    // Return to the same floor with no motor command is accepted
    motorSubindo = 1'b0;
    sensoresNeg = 4'b1111;
    observa(10, pb, nb, pi, pf, du);
    sensoresNeg = 4'b1101;
    observa(10, pb, nb, pi, pf, du);
    verifica("ret_borda_ciclo", pb, 7);
    verifica("ret_andar", andarAtual, 1);
    verifica("ret_sem_falha", pf, 0);

    // 4: skip from floor 1 to floor 3
    motorSubindo = 1'b1;
    sensoresNeg = 4'b1111;
    observa(10, pb, nb, pi, pf, du);
    sensoresNeg = 4'b0111;
    observa(10, pb, nb, pi, pf, du);
    verifica("t4_falha_ciclo", pf, 7);
    verifica("t4_sem_borda", nb, 0);
    verifica("t4_andar", andarAtual, 1);
    verifica("t4_valido", andarValido, 0);
    reinicia(4'b1111);
    verifica("t4_rst_falha", falhaSensor, 0);
    verifica("t4_rst_andar", andarAtual, 0);

    // 5: at floor 2, commanded down, arrives at floor 3
    reinicia(4'b1011);
    observa(10, pb, nb, pi, pf, du);
    verifica("t5_andar2", andarAtual, 2);
    motorDescendo = 1'b1;
    sensoresNeg = 4'b1111;
    observa(10, pb, nb, pi, pf, du);
    sensoresNeg = 4'b0111;
    observa(10, pb, nb, pi, pf, du);
    verifica("t5_falha", falhaSensor, 1);
    verifica("t5_sem_borda", nb, 0);
    verifica("t5_andar", andarAtual, 2);

    // Both motor commands high: floor change rejected
    reinicia(4'b1011);
    observa(10, pb, nb, pi, pf, du);
    motorSubindo = 1'b1;
    motorDescendo = 1'b1;
    sensoresNeg = 4'b1111;
    observa(10, pb, nb, pi, pf, du);
    sensoresNeg = 4'b0111;
    observa(10, pb, nb, pi, pf, du);
    verifica("ambos_falha", falhaSensor, 1);
    verifica("ambos_andar", andarAtual, 2);

    // 6: two sensors active at floor 1
    reinicia(4'b1101);
    observa(10, pb, nb, pi, pf, du);
    verifica("t6_andar1", andarAtual, 1);
    sensoresNeg = 4'b1001;
    observa(10, pb, nb, pi, pf, du);
    verifica("t6_falha_ciclo", pf, 7);
    verifica("t6_andar", andarAtual, 1);

    // 6b: same, reset mid-count discards history
    reinicia(4'b1101);
    observa(10, pb, nb, pi, pf, du);
    sensoresNeg = 4'b1001;
    ciclos(4);
    reset = 1'b0;
    ciclos(1);
    verifica("t6b_andar", andarAtual, 0);
    verifica("t6b_valido", andarValido, 0);
    verifica("t6b_falha", falhaSensor, 0);
    verifica("t6b_filtro", db_filtrado, 0);
    sensoresNeg = 4'b1111;
    ciclos(1);
    reset = 1'b1;
    observa(10, pb, nb, pi, pf, du);
    verifica("t6b_inicial_valido", andarValido, 0);
    verifica("t6b_inicial_falha", falhaSensor, 0);
    sensoresNeg = 4'b1110;
    observa(12, pb, nb, pi, pf, du);
    verifica("t6b_aceita_ciclo", pb, 7);
    verifica("t6b_aceita_andar", andarAtual, 0);
    verifica("t6b_sem_dupla", du, 0);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
